ldm_acc_sequencer: RTL and testbench
====================================

# ldm_acc_sequencer

Parametrised successor to the sleep-mode controller. It sits between the RISC core's decode stage and the DM/PM/WM memories and the MNIST accelerator, and executes three opcodes. LDM streams a configurable number of DM words into PM and then into WM. MNIST runs a start/done handshake with the accelerator and writes back the result. OUT raises the output and halt flags. While a multi-cycle opcode is in progress, the block freezes the PC.

## Interface
Parameters:
- DATA_W, 64, memory word width
- ADDR_W, 8, DM/PM/WM address width; PM_LEN+WM_LEN must be ≤ 2^ADDR_W
- PM_LEN, 100, words copied DM[0..PM_LEN-1] → PM[0..PM_LEN-1]
- WM_LEN, 28, words copied DM[PM_LEN..PM_LEN+WM_LEN-1] → WM[0..WM_LEN-1]
- ACC_TIMEOUT, 1023, cycles in ACC_WAIT before timeout (used only with SMC_ACC_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all registers on posedge
- rst_n  in  1  reset, asynchronous assert, active-low
- instr  in  16  current instruction; opcode is instr[15:11] (LDM=01100, MNIST=10111, OUT=11100)
- freeze_pc  out  1  combinational PC hold
- dm_addr  out  ADDR_W  DM read address; DM has 1-cycle synchronous read latency
- dm_rdata  in  DATA_W  DM read data
- wr_addr  out  ADDR_W  PM/WM write address
- wr_data  out  DATA_W  PM/WM write data
- pm_wr  out  1  PM write strobe
- wm_wr  out  1  WM write strobe
- acc_start  out  1  accelerator start pulse
- acc_busy  in  1  accelerator running
- acc_done  in  1  accelerator result valid
- reg_write  out  1  register-file write-back strobe
- out_r  out  1  output flag
- hlt  out  1  halt flag, sticky
- acc_timeout  out  1  sticky accelerator-timeout flag

## Operation
- States: IDLE, LOAD, LOAD_DONE, ACC_WAIT, ACC_DONE. rd_cnt is a read counter of width ADDR_W+1.
- IDLE behaviour by opcode:
  - LDM: enter LOAD; dm_addr←0; rd_cnt←1.
  - MNIST: enter ACC_WAIT; acc_start←1 for exactly one cycle.
  - Any other opcode: stay in IDLE; all strobes 0.
- LOAD, each cycle:
  - Write the word read on the previous cycle. Source index a=rd_cnt-1 (registered). If a<PM_LEN: pm_wr=1, wr_addr=a. Otherwise: wm_wr=1, wr_addr=a-PM_LEN. wr_data=dm_rdata.
  - While rd_cnt<PM_LEN+WM_LEN: dm_addr←rd_cnt and rd_cnt increments. Otherwise dm_addr holds.
  - When the write of index PM_LEN+WM_LEN-1 is issued, go to LOAD_DONE.
- LOAD_DONE: pm_wr and wm_wr return to 0 on the next edge; state → IDLE unconditionally. A back-to-back LDM restarts from index 0.
- ACC_WAIT: acc_done is sampled only in this state. When acc_done=1 and acc_busy=0, go to ACC_DONE with reg_write=1 for one cycle.
- ACC_DONE: reg_write→0; state → IDLE.
- OUT (registered, evaluated every cycle):
  - out_r←(opcode==OUT)&~instr[0].
  - hlt←hlt|((opcode==OUT)&instr[0]).
- freeze_pc = (opcode==LDM & state≠LOAD_DONE) | (opcode==MNIST & state≠ACC_DONE).
- Reset, including mid-LOAD or mid-ACC_WAIT: state=IDLE, rd_cnt=0, every output register=0 (dm_addr, wr_addr, wr_data, pm_wr, wm_wr, acc_start, reg_write, out_r, hlt, acc_timeout). No partial write is issued after reset deasserts.

## Timing
- Cycles are numbered from cycle 0, the first cycle LDM is presented in IDLE.
- LDM:
  - freeze_pc is high in cycles 0..N-1, where N=PM_LEN+WM_LEN, and low in cycle N (LOAD_DONE).
  - Write strobes are high in cycles 1..N, one word per cycle, with no gaps at the PM→WM boundary.
  - The PM/WM write and the PC advance occur on the same edge, at the end of cycle N.
- MNIST:
  - acc_start is high in cycle 1 only.
  - reg_write and freeze_pc low occur together, in the cycle after acc_done&~acc_busy is sampled.
  - acc_done in IDLE, LOAD or LOAD_DONE is ignored.
- OUT: out_r and hlt are visible one cycle after decode.

## Configuration
- SMC_ACC_TIMEOUT_EN defined:
  - A counter of width clog2(ACC_TIMEOUT+1) runs in ACC_WAIT.
  - After ACC_TIMEOUT cycles without done: acc_timeout←1 (sticky until reset), state→ACC_DONE with reg_write=0, and the PC is released.
  - If acc_done and the terminal count coincide, done wins: reg_write=1 and acc_timeout is unchanged.
- SMC_ACC_TIMEOUT_EN undefined: ACC_WAIT waits indefinitely; acc_timeout is tied to 0.

## Test plan
- Defaults, DM[i]=i·0x0101: LDM → 100 pm_wr pulses with PM[k]=k·0x0101, then 28 wm_wr pulses with WM[0]=100·0x0101; freeze_pc high exactly 128 cycles.
- PM_LEN=3, WM_LEN=2 → strobes in cycles 1–5: pm,pm,pm,wm,wm; wr_addr 0,1,2,0,1; freeze_pc low in cycle 5.
- Reset asserted in cycle 40 of an LDM, then LDM re-presented → all outputs 0 during reset; copy restarts at DM[0], with no write to PM[39+].
- MNIST with acc_done at cycle 10 while acc_busy=1, then acc_busy=0 at cycle 12 → acc_start high in cycle 1 only; reg_write high in cycle 13; freeze_pc low in cycle 13.
- With SMC_ACC_TIMEOUT_EN and ACC_TIMEOUT=8, MNIST with acc_done never asserted → acc_timeout=1, reg_write=0, freeze_pc released at cycle 10; acc_timeout stays 1 across later instructions.
- OUT with instr[0]=0, then OUT with instr[0]=1, then a NOP → out_r=1 then 0; hlt=1 and remains 1 after the NOP.

Source files
------------

// File: rtl/ldm_acc_sequencer.sv
// ldm_acc_sequencer
//
// Sequencer between the core's decode stage, the DM/PM/WM memories and the
// MNIST accelerator. Executes three opcodes taken from instr[15:11]:
//   LDM   (01100) copies DM[0..PM_LEN-1] into PM and DM[PM_LEN..] into WM
//   MNIST (10111) pulses acc_start, waits for acc_done and strobes reg_write
//   OUT   (11100) drives out_r (instr[0]=0) or sets the sticky hlt (instr[0]=1)
// freeze_pc holds the PC while a multi-cycle opcode is still in progress.
//
// Ports:
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   instr               current instruction from decode
//   freeze_pc           combinational PC hold
//   dm_addr, dm_rdata   DM read port (DM returns data one cycle after the address)
//   wr_addr, wr_data    shared PM/WM write port
//   pm_wr, wm_wr        PM / WM write strobes
//   acc_start           one-cycle accelerator start pulse
//   acc_busy, acc_done  accelerator status
//   reg_write           register-file write-back strobe for the MNIST result
//   out_r, hlt          output flag and sticky halt flag
//   acc_timeout         sticky accelerator timeout flag
//
// Optional feature: define SMC_ACC_TIMEOUT_EN to abandon ACC_WAIT after
// ACC_TIMEOUT cycles without acc_done. Without it acc_timeout is tied to 0.
module ldm_acc_sequencer #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 8,
    parameter int PM_LEN      = 100,
    parameter int WM_LEN      = 28,
    parameter int ACC_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       instr,
    output logic              freeze_pc,
    output logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              pm_wr,
    output logic              wm_wr,
    output logic              acc_start,
    input  logic              acc_busy,
    input  logic              acc_done,
    output logic              reg_write,
    output logic              out_r,
    output logic              hlt,
    output logic              acc_timeout
);

    localparam logic [4:0] OP_LDM   = 5'b01100;
    localparam logic [4:0] OP_MNIST = 5'b10111;
    localparam logic [4:0] OP_OUT   = 5'b11100;

    localparam int              CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] PM_END = CNT_W'(PM_LEN);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(PM_LEN + WM_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_DONE,
        ACC_WAIT,
        ACC_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0]  dm_addr_q, dm_addr_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic               pm_wr_q, pm_wr_d;
    logic               wm_wr_q, wm_wr_d;
    logic               acc_start_q, acc_start_d;
    logic               reg_write_q, reg_write_d;
    logic               out_r_q, out_r_d;
    logic               hlt_q, hlt_d;
    logic               issue;
    logic [CNT_W-1:0]   idx;

    logic [4:0] opcode;
    logic       is_ldm, is_mnist, is_out;

    assign opcode   = instr[15:11];
    assign is_ldm   = (opcode == OP_LDM);
    assign is_mnist = (opcode == OP_MNIST);
    assign is_out   = (opcode == OP_OUT);

    logic unused_ok;
    assign unused_ok = ^{instr[10:1], (ACC_TIMEOUT != 0)};

`ifdef SMC_ACC_TIMEOUT_EN
    localparam int              TO_W    = $clog2(ACC_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACC_TIMEOUT);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            acc_timeout_q, acc_timeout_d;
    assign acc_timeout = acc_timeout_q;
`else
    assign acc_timeout = 1'b0;
`endif

    // Next-state logic. During a load, each cycle issues one DM index: its
    // address goes to DM now and its registered write strobe appears next
    // cycle, exactly when DM returns the word. The index issued from IDLE is
    // always 0, so a back-to-back LDM restarts the copy from the beginning.
    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        dm_addr_d   = dm_addr_q;
        wr_addr_d   = wr_addr_q;
        pm_wr_d     = 1'b0;
        wm_wr_d     = 1'b0;
        acc_start_d = 1'b0;
        reg_write_d = 1'b0;
        issue       = 1'b0;
        idx         = '0;
`ifdef SMC_ACC_TIMEOUT_EN
        to_cnt_d      = '0;
        acc_timeout_d = acc_timeout_q;
`endif

        case (state_q)
            IDLE: begin
                if (is_ldm) begin
                    issue    = 1'b1;
                    idx      = '0;
                    rd_cnt_d = CNT_W'(1);
                    state_d  = (LAST == '0) ? LOAD_DONE : LOAD;
                end else if (is_mnist) begin
                    acc_start_d = 1'b1;
                    state_d     = ACC_WAIT;
                end
            end
            LOAD: begin
                issue    = 1'b1;
                idx      = rd_cnt_q;
                rd_cnt_d = rd_cnt_q + CNT_W'(1);
                if (rd_cnt_q == LAST) begin
                    state_d = LOAD_DONE;
                end
            end
            LOAD_DONE: begin
                state_d = IDLE;
            end
            ACC_WAIT: begin
                // A done coinciding with the terminal count takes priority.
                if (acc_done && !acc_busy) begin
                    reg_write_d = 1'b1;
                    state_d     = ACC_DONE;
                end
`ifdef SMC_ACC_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    acc_timeout_d = 1'b1;
                    state_d       = ACC_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
            ACC_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            dm_addr_d = ADDR_W'(idx);
            if (idx < PM_END) begin
                pm_wr_d   = 1'b1;
                wr_addr_d = ADDR_W'(idx);
            end else begin
                wm_wr_d   = 1'b1;
                wr_addr_d = ADDR_W'(idx - PM_END);
            end
        end

        out_r_d = is_out & ~instr[0];
        hlt_d   = hlt_q | (is_out & instr[0]);
    end

    // State and output registers; reset abandons any copy or handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_cnt_q    <= '0;
            dm_addr_q   <= '0;
            wr_addr_q   <= '0;
            pm_wr_q     <= 1'b0;
            wm_wr_q     <= 1'b0;
            acc_start_q <= 1'b0;
            reg_write_q <= 1'b0;
            out_r_q     <= 1'b0;
            hlt_q       <= 1'b0;
`ifdef SMC_ACC_TIMEOUT_EN
            to_cnt_q      <= '0;
            acc_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            dm_addr_q   <= dm_addr_d;
            wr_addr_q   <= wr_addr_d;
            pm_wr_q     <= pm_wr_d;
            wm_wr_q     <= wm_wr_d;
            acc_start_q <= acc_start_d;
            reg_write_q <= reg_write_d;
            out_r_q     <= out_r_d;
            hlt_q       <= hlt_d;
`ifdef SMC_ACC_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
            acc_timeout_q <= acc_timeout_d;
`endif
        end
    end

    // DM registers its address internally, so it is fed the pointer's next
    // value; the word then arrives together with the registered strobe.
    // Write data is forced to zero whenever no write is in flight.
    assign dm_addr   = dm_addr_d;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = (pm_wr_q | wm_wr_q) ? dm_rdata : '0;
    assign pm_wr     = pm_wr_q;
    assign wm_wr     = wm_wr_q;
    assign acc_start = acc_start_q;
    assign reg_write = reg_write_q;
    assign out_r     = out_r_q;
    assign hlt       = hlt_q;

    assign freeze_pc = (is_ldm & (state_q != LOAD_DONE)) |
                       (is_mnist & (state_q != ACC_DONE));

endmodule

// File: tb/tb_ldm_acc_sequencer.sv
// Directed testbench for ldm_acc_sequencer.
// Instance A uses the default copy lengths (100 + 28 words); instance B uses
// PM_LEN=3, WM_LEN=2 for a cycle-exact look at the PM/WM boundary.
module tb_ldm_acc_sequencer;

    localparam logic [15:0] I_NOP   = 16'h0000;
    localparam logic [15:0] I_LDM   = {5'b01100, 11'd0};
    localparam logic [15:0] I_MNIST = {5'b10111, 11'd0};
    localparam logic [15:0] I_OUT0  = {5'b11100, 11'd0};
    localparam logic [15:0] I_OUT1  = {5'b11100, 11'd1};

`ifdef SMC_ACC_TIMEOUT_EN
    localparam int   DONE_AT = 4;
    localparam int   FREE_AT = 6;
    localparam logic EXP_TO  = 1'b1;
`else
    localparam int   DONE_AT = 10;
    localparam int   FREE_AT = 12;
    localparam logic EXP_TO  = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    logic [15:0] instrA, instrB;
    logic        freezeA, freezeB;
    logic [7:0]  dmAddrA, dmAddrB, wrAddrA, wrAddrB;
    logic [63:0] dmRdataA, dmRdataB, wrDataA, wrDataB;
    logic        pmWrA, pmWrB, wmWrA, wmWrB;
    logic        accStartA, accStartB, accBusy, accDone;
    logic        regWriteA, regWriteB, outRA, outRB, hltA, hltB;
    logic        accTimeoutA, accTimeoutB;

    logic [63:0] dmMem [0:255];
    always @(posedge clk) dmRdataA <= dmMem[dmAddrA];
    always @(posedge clk) dmRdataB <= dmMem[dmAddrB];

    int regWriteSeen = 0;
    always @(negedge clk) if (regWriteA) regWriteSeen <= regWriteSeen + 1;

    ldm_acc_sequencer #(.DATA_W(64), .ADDR_W(8), .PM_LEN(100), .WM_LEN(28), .ACC_TIMEOUT(8)) dutA (
        .clk(clk), .rst_n(rstN), .instr(instrA), .freeze_pc(freezeA),
        .dm_addr(dmAddrA), .dm_rdata(dmRdataA), .wr_addr(wrAddrA), .wr_data(wrDataA),
        .pm_wr(pmWrA), .wm_wr(wmWrA), .acc_start(accStartA), .acc_busy(accBusy),
        .acc_done(accDone), .reg_write(regWriteA), .out_r(outRA), .hlt(hltA),
        .acc_timeout(accTimeoutA)
    );

    ldm_acc_sequencer #(.DATA_W(64), .ADDR_W(8), .PM_LEN(3), .WM_LEN(2), .ACC_TIMEOUT(8)) dutB (
        .clk(clk), .rst_n(rstN), .instr(instrB), .freeze_pc(freezeB),
        .dm_addr(dmAddrB), .dm_rdata(dmRdataB), .wr_addr(wrAddrB), .wr_data(wrDataB),
        .pm_wr(pmWrB), .wm_wr(wmWrB), .acc_start(accStartB), .acc_busy(1'b0),
        .acc_done(1'b0), .reg_write(regWriteB), .out_r(outRB), .hlt(hltB),
        .acc_timeout(accTimeoutB)
    );

    int passCount  = 0;
    int checkCount = 0;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Advance to the next cycle and present new instructions just after the edge.
    task automatic applyStimulus(input logic [15:0] nextA, input logic [15:0] nextB);
        @(posedge clk);
        #1;
        instrA = nextA;
        instrB = nextB;
    endtask

    // Full default-length LDM on instance A, cycle 0 being the first LDM cycle.
    task automatic runLoadA(input string tag);
        int n = 128;
        int pmCnt = 0, wmCnt = 0, freezeCnt = 0, seqErr = 0;
        int k, expAddr;
        logic expPm;
        logic [63:0] firstWm = '1;
        applyStimulus(I_LDM, I_NOP);
        for (int c = 0; c <= n + 2; c++) begin
            @(negedge clk);
            if (freezeA) freezeCnt++;
            if (pmWrA) pmCnt++;
            if (wmWrA) begin
                if (wmCnt == 0) firstWm = wrDataA;
                wmCnt++;
            end
            if (c >= 1 && c <= n) begin
                k       = c - 1;
                expPm   = (k < 100);
                expAddr = expPm ? k : k - 100;
                if (pmWrA !== expPm || wmWrA !== !expPm || wrAddrA !== 8'(expAddr) ||
                    wrDataA !== 64'(k) * 64'h0101) seqErr++;
            end else if (pmWrA || wmWrA) begin
                seqErr++;
            end
            if (c == n) checkOutput({tag, " freeze low in LOAD_DONE"}, 64'(freezeA), 64'd0);
            applyStimulus((c >= n) ? I_NOP : I_LDM, I_NOP);
        end
        checkOutput({tag, " pm pulses"}, 64'(pmCnt), 64'd100);
        checkOutput({tag, " wm pulses"}, 64'(wmCnt), 64'd28);
        checkOutput({tag, " freeze cycles"}, 64'(freezeCnt), 64'd128);
        checkOutput({tag, " WM[0] data"}, firstWm, 64'd100 * 64'h0101);
        checkOutput({tag, " write sequence errors"}, 64'(seqErr), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pmCnt, lastAddr, strobes, frozen, toSeen, startCnt, rwBase;
        logic [2:0] pmTab, wmTab;
        logic [7:0] addrTab [0:4];

        for (int i = 0; i < 256; i++) dmMem[i] = 64'(i) * 64'h0101;
        instrA  = I_NOP;
        instrB  = I_NOP;
        accBusy = 1'b0;
        accDone = 1'b0;
        rstN    = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset flags", {48'd0, dmAddrA, wrAddrA, pmWrA, wmWrA, accStartA, regWriteA,
                                    outRA, hltA, accTimeoutA, freezeA},
                    64'd0);
        checkOutput("reset wr_data", wrDataA, 64'd0);
        @(posedge clk);
        #1 rstN = 1'b1;

        // Default-length LDM
        runLoadA("ldm default");

        // Small instance: hand-computed strobe table for cycles 1..5
        pmTab = 3'b111;
        wmTab = 3'b000;
        addrTab[0] = 8'd0; addrTab[1] = 8'd1; addrTab[2] = 8'd2; addrTab[3] = 8'd0; addrTab[4] = 8'd1;
        applyStimulus(I_NOP, I_LDM);
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 5) begin
                checkOutput($sformatf("small pm_wr c%0d", c), 64'(pmWrB), 64'(c <= 3 ? pmTab[c-1] : 1'b0));
                checkOutput($sformatf("small wm_wr c%0d", c), 64'(wmWrB), 64'(c >= 4 ? 1'b1 : wmTab[0]));
                checkOutput($sformatf("small wr_addr c%0d", c), 64'(wrAddrB), 64'(addrTab[c-1]));
                checkOutput($sformatf("small wr_data c%0d", c), wrDataB, 64'(c - 1) * 64'h0101);
            end
            if (c == 4) checkOutput("small freeze c4", 64'(freezeB), 64'd1);
            if (c == 5) checkOutput("small freeze c5", 64'(freezeB), 64'd0);
            if (c == 6) checkOutput("small idle strobes c6", 64'({pmWrB, wmWrB}), 64'd0);
            applyStimulus(I_NOP, (c >= 5) ? I_NOP : I_LDM);
        end

        // Reset in cycle 40 of an LDM
        pmCnt    = 0;
        lastAddr = -1;
        applyStimulus(I_LDM, I_NOP);
        for (int c = 0; c <= 39; c++) begin
            @(negedge clk);
            if (pmWrA) begin
                pmCnt++;
                lastAddr = int'(wrAddrA);
            end
            if (c < 39) applyStimulus(I_LDM, I_NOP);
        end
        @(posedge clk);
        #1;
        rstN   = 1'b0;
        instrA = I_NOP;
        @(negedge clk);
        checkOutput("mid-load reset flags", {48'd0, dmAddrA, wrAddrA, pmWrA, wmWrA, accStartA,
                                             regWriteA, outRA, hltA, accTimeoutA, freezeA},
                    64'd0);
        checkOutput("mid-load reset wr_data", wrDataA, 64'd0);
        checkOutput("pm writes before reset", 64'(pmCnt), 64'd39);
        checkOutput("last pm addr before reset", 64'(lastAddr), 64'd38);
        @(posedge clk);
        #1 rstN = 1'b1;
        strobes = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (pmWrA || wmWrA) strobes++;
        end
        checkOutput("no strobes after reset", 64'(strobes), 64'd0);

        // Restarted copy, with acc_done held high to show it is ignored outside ACC_WAIT
        accDone = 1'b1;
        rwBase  = regWriteSeen;
        runLoadA("ldm after reset");
        @(negedge clk);
        checkOutput("acc_done ignored outside ACC_WAIT", 64'(regWriteSeen - rwBase), 64'd0);
        accDone = 1'b0;

        // MNIST handshake: done while busy, then busy drops
        startCnt = 0;
        rwBase   = regWriteSeen;
        applyStimulus(I_MNIST, I_NOP);
        for (int c = 0; c <= FREE_AT + 3; c++) begin
            @(negedge clk);
            if (accStartA) startCnt++;
            if (c == 0) checkOutput("mnist freeze c0", 64'(freezeA), 64'd1);
            if (c == 1) checkOutput("acc_start c1", 64'(accStartA), 64'd1);
            if (c == FREE_AT) checkOutput("mnist freeze before done", 64'({freezeA, regWriteA}), 64'b10);
            if (c == FREE_AT + 1) checkOutput("reg_write and release", 64'({freezeA, regWriteA}), 64'b01);
            @(posedge clk);
            #1;
            accBusy = (c + 1 >= 1) && (c + 1 < FREE_AT);
            accDone = (c + 1 >= DONE_AT) && (c + 1 <= FREE_AT);
            instrA  = (c + 1 <= FREE_AT + 1) ? I_MNIST : I_NOP;
        end
        checkOutput("acc_start pulse count", 64'(startCnt), 64'd1);
        checkOutput("reg_write pulse count", 64'(regWriteSeen - rwBase), 64'd1);
        accBusy = 1'b0;
        accDone = 1'b0;

`ifdef SMC_ACC_TIMEOUT_EN
        // Timeout after 8 waiting cycles, PC released in cycle 10
        rwBase = regWriteSeen;
        applyStimulus(I_MNIST, I_NOP);
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            if (c == 9) checkOutput("timeout c9", 64'({freezeA, accTimeoutA}), 64'b10);
            if (c == 10) checkOutput("timeout c10", 64'({freezeA, accTimeoutA}), 64'b01);
            applyStimulus((c >= 10) ? I_NOP : I_MNIST, I_NOP);
        end
        checkOutput("timeout reg_write count", 64'(regWriteSeen - rwBase), 64'd0);
`else
        // Without the timeout feature ACC_WAIT holds indefinitely
        frozen = 0;
        toSeen = 0;
        applyStimulus(I_MNIST, I_NOP);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (freezeA) frozen++;
            if (accTimeoutA) toSeen++;
            applyStimulus(I_MNIST, I_NOP);
        end
        checkOutput("long wait frozen cycles", 64'(frozen), 64'd30);
        checkOutput("long wait timeout flag", 64'(toSeen), 64'd0);
        accDone = 1'b1;
        @(negedge clk);
        checkOutput("late done sampled", 64'({freezeA, regWriteA}), 64'b10);
        applyStimulus(I_MNIST, I_NOP);
        accDone = 1'b0;
        @(negedge clk);
        checkOutput("late done write-back", 64'({freezeA, regWriteA}), 64'b01);
        applyStimulus(I_NOP, I_NOP);
`endif

        // OUT flags
        applyStimulus(I_OUT0, I_NOP);
        @(negedge clk);
        checkOutput("out c0", 64'({outRA, hltA, freezeA}), 64'b000);
        applyStimulus(I_OUT1, I_NOP);
        @(negedge clk);
        checkOutput("out c1", 64'({outRA, hltA}), 64'b10);
        applyStimulus(I_NOP, I_NOP);
        @(negedge clk);
        checkOutput("out c2", 64'({outRA, hltA}), 64'b01);
        applyStimulus(I_NOP, I_NOP);
        @(negedge clk);
        checkOutput("hlt sticky", 64'({outRA, hltA}), 64'b01);
        checkOutput("acc_timeout after later instructions", 64'(accTimeoutA), 64'(EXP_TO));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
